// File: rtl/oneapi_gasket_pkg.sv
// Shared types and width helpers for the oneAPI AXI4-Stream to Avalon-ST video gasket.
package oneapi_gasket_pkg;

    typedef struct packed {
        logic sop;
        logic eop;
    } gasket_ctl_t;

    localparam int CTL_BITS = $bits(gasket_ctl_t);

    function automatic int bpc_av(input int bpc);
        return 32'sd1 << $clog2(bpc);
    endfunction

    function automatic int bpp_axi(input int channels, input int bpc);
        return 32'sd8 * ((channels * bpc + 32'sd7) / 32'sd8);
    endfunction

    function automatic int tuser_bits(input int bits_axi);
        return (bits_axi + 32'sd7) / 32'sd8;
    endfunction

    function automatic int empty_bits(input int bits_av);
        return $clog2(bits_av / 32'sd8);
    endfunction

endpackage

// File: rtl/oneapi_gasket_beat_fifo.sv
// Show-ahead beat buffer: head entry is always visible on rd_data, flags are registered.
module oneapi_gasket_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    assign push_s  = wr_en & ~full_r;
    assign pop_s   = rd_en & ~empty_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW + 1)'(1'b1);
            2'b01:   count_next_s = count_r - (AW + 1)'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and registered flags; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_CNT);
            empty_r <= (count_next_s == '0);
        end
    end

endmodule

// File: rtl/oneapi_axi_to_avalon_vid_gasket.sv
// AXI4-Stream to Avalon-ST video gasket: unpacks byte-padded pixels, buffers beats,
// tracks lines per frame to place end-of-packet, and flags malformed frames.
module oneapi_axi_to_avalon_vid_gasket
    import oneapi_gasket_pkg::*;
#(
    parameter int PARALLEL_PIXELS  = 2,
    parameter int BITS_PER_CHANNEL = 10,
    parameter int CHANNELS         = 3,
    parameter int FIFO_DEPTH       = 4,
    parameter int EOP_MODE         = 1,
    parameter int LINES_PER_FRAME  = 4,
    localparam int BPC_AV     = bpc_av(BITS_PER_CHANNEL),
    localparam int BPP_AXI    = bpp_axi(CHANNELS, BITS_PER_CHANNEL),
    localparam int BITS_AXI   = BPP_AXI * PARALLEL_PIXELS,
    localparam int BITS_AV    = BPC_AV * CHANNELS * PARALLEL_PIXELS,
    localparam int TUSER_BITS = tuser_bits(BITS_AXI),
    localparam int EMPTY_BITS = empty_bits(BITS_AV),
    localparam int LC_BITS    = $clog2(LINES_PER_FRAME + 1)
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    output logic                  axs_tready,
    input  logic                  axs_tvalid,
    input  logic [BITS_AXI-1:0]   axs_tdata,
    input  logic                  axs_tlast,
    input  logic [TUSER_BITS-1:0] axs_tuser,
    input  logic                  aso_ready,
    output logic                  aso_valid,
    output logic [BITS_AV-1:0]    aso_data,
    output logic                  aso_startofpacket,
    output logic                  aso_endofpacket,
    output logic [EMPTY_BITS-1:0] aso_empty,
    output logic                  frame_err,
    output logic [LC_BITS-1:0]    line_count
);

    localparam int ENTRY_BITS = CTL_BITS + BITS_AV;
    localparam logic [LC_BITS-1:0] LAST_LINE = LC_BITS'(LINES_PER_FRAME - 1);

    logic [BITS_AV-1:0]    av_data_s;
    logic [LC_BITS-1:0]    lc_base_s;
    logic [LC_BITS-1:0]    lc_next_s;
    logic                  lc_wrap_s;
    logic                  eop_s;
    logic                  err_s;
    logic                  accept_s;
    logic                  pop_s;
    gasket_ctl_t           wr_ctl_s;
    gasket_ctl_t           rd_ctl_s;
    logic [ENTRY_BITS-1:0] rd_entry_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  ready_en_r;
    logic                  first_r;
    logic                  frame_err_r;
    logic [LC_BITS-1:0]    line_count_r;
    logic                  unused_s;

    assign accept_s = axs_tvalid & axs_tready;
    assign pop_s    = aso_valid & aso_ready;
    assign unused_s = ^{axs_tdata, axs_tuser};

    // Zero-extend each channel into a power-of-2 slot; AXI pad bits are never read.
    always_comb begin
        av_data_s = '0;
        for (int p = 0; p < PARALLEL_PIXELS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                av_data_s[(p * CHANNELS + c) * BPC_AV +: BITS_PER_CHANNEL] =
                    axs_tdata[p * BPP_AXI + c * BITS_PER_CHANNEL +: BITS_PER_CHANNEL];
            end
        end
    end

    // Next line index, frame wrap and framing check for the beat currently offered.
    always_comb begin
        lc_wrap_s = 1'b0;
        if (axs_tuser[0]) begin
            lc_base_s = '0;
        end else begin
            lc_base_s = line_count_r;
        end
        if (axs_tlast) begin
            if (lc_base_s == LAST_LINE) begin
                lc_next_s = '0;
                lc_wrap_s = 1'b1;
            end else begin
                lc_next_s = lc_base_s + LC_BITS'(1'b1);
            end
        end else begin
            lc_next_s = lc_base_s;
        end
        if (EOP_MODE == 32'sd1) begin
            eop_s = lc_wrap_s;
        end else begin
            eop_s = axs_tlast;
        end
        err_s = (axs_tuser[0] && (line_count_r != '0)) || (first_r && !axs_tuser[0]);
    end

    assign wr_ctl_s.sop = axs_tuser[0];
    assign wr_ctl_s.eop = eop_s;

    oneapi_gasket_beat_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk     (csi_clk),
        .rst_n   (rsi_reset_n),
        .wr_en   (accept_s),
        .wr_data ({wr_ctl_s, av_data_s}),
        .rd_en   (pop_s),
        .rd_data (rd_entry_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign rd_ctl_s = gasket_ctl_t'(rd_entry_s[ENTRY_BITS-1 -: CTL_BITS]);

    // Line counter, first-beat tracking and the one-cycle error pulse.
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            ready_en_r   <= 1'b0;
            first_r      <= 1'b1;
            frame_err_r  <= 1'b0;
            line_count_r <= '0;
        end else begin
            ready_en_r  <= 1'b1;
            frame_err_r <= accept_s & err_s;
            if (accept_s) begin
                first_r      <= 1'b0;
                line_count_r <= lc_next_s;
            end
        end
    end

    assign axs_tready        = ready_en_r & ~fifo_full_s;
    assign aso_valid         = ~fifo_empty_s;
    assign aso_data          = aso_valid ? rd_entry_s[BITS_AV-1:0] : '0;
    assign aso_startofpacket = aso_valid & rd_ctl_s.sop;
    assign aso_endofpacket   = aso_valid & rd_ctl_s.eop;
    assign aso_empty         = '0;
    assign frame_err         = frame_err_r;
    assign line_count        = line_count_r;

endmodule
